// File: rtl/ascii_hex_parser.sv
// ASCII hex line parser: accumulates hex digits MSB-first and emits the word on a valid/ready handshake.
// Optional macro ASCII_HEX_LOWERCASE_EN also accepts 'a'-'f' as digits.
module ascii_hex_parser #(
  parameter int NUM_DIGITS = 8,
  parameter int CW         = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              ascii_in,
  input  logic                    ascii_valid,
  output logic                    ascii_ready,
  output logic [4*NUM_DIGITS-1:0] word_out,
  output logic [CW-1:0]           digit_count,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    parse_err
);

  localparam int WW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE,
    DISCARD
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   word_q, word_d;
  logic [CW-1:0]   dcnt_q, dcnt_d;
  logic            err_q, err_d;

  logic            isDigit;
  logic            isTerm;
  logic [3:0]      nibble;
  logic            accept;

  // Letters share the low nibble pattern 1..6, so A-F (and a-f) map to low nibble + 9.
  always_comb begin
    isDigit = 1'b0;
    isTerm  = 1'b0;
    nibble  = 4'd0;
    if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
      isDigit = 1'b1;
      nibble  = ascii_in[3:0];
    end else if (ascii_in >= 8'h41 && ascii_in <= 8'h46) begin
      isDigit = 1'b1;
      nibble  = ascii_in[3:0] + 4'd9;
`ifdef ASCII_HEX_LOWERCASE_EN
    end else if (ascii_in >= 8'h61 && ascii_in <= 8'h66) begin
      isDigit = 1'b1;
      nibble  = ascii_in[3:0] + 4'd9;
`else
`endif
    end else if (ascii_in == 8'h0D || ascii_in == 8'h0A) begin
      isTerm = 1'b1;
    end
  end

  assign ascii_ready = (state_q != DONE);
  assign accept      = ascii_valid && ascii_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    dcnt_d  = dcnt_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (isDigit) begin
            acc_d   = WW'(nibble);
            cnt_d   = CW'(1);
            state_d = ACCUM;
          end else if (!isTerm) begin
            state_d = DISCARD;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          if (isDigit) begin
            if (cnt_q == CW'(NUM_DIGITS)) begin
              state_d = DISCARD;
            end else begin
              acc_d = (acc_q << 4) | WW'(nibble);
              cnt_d = cnt_q + CW'(1);
            end
          end else if (isTerm) begin
            word_d  = acc_q;
            dcnt_d  = cnt_q;
            state_d = DONE;
          end else begin
            state_d = DISCARD;
          end
        end
      end

      DONE: begin
        if (word_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      DISCARD: begin
        // The whole line, terminator included, is swallowed before the error pulse.
        if (accept && isTerm) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
    end
  end

  assign word_out    = word_q;
  assign digit_count = dcnt_q;
  assign word_valid  = (state_q == DONE);
  assign parse_err   = err_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Bench for ascii_hex_parser: table of whole lines, hand-written corner sequences and random
// traffic, all compared each cycle against a line-buffer reference model.
module tb_ascii_hex_parser;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    ascii_in = 8'h00;
  logic          ascii_valid = 1'b0;
  logic          ascii_ready;
  logic [4*N-1:0] word_out;
  logic [CW-1:0] digit_count;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic          parse_err;

  ascii_hex_parser #(.NUM_DIGITS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .ascii_in    (ascii_in),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .word_out    (word_out),
    .digit_count (digit_count),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .parse_err   (parse_err)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Reference model: buffers the raw characters of the current line and judges it at the terminator.
  logic [7:0]  lineQ[$];
  bit          lineBad = 1'b0;
  bit          mValid = 1'b0;
  logic [31:0] mWord = 32'h0;
  int          mCnt = 0;
  bit          mErr = 1'b0;
  bit          modelLive = 1'b0;

  function automatic int hexValue(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
`ifdef ASCII_HEX_LOWERCASE_EN
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
`endif
    return -1;
  endfunction

  function automatic bit isTermChar(input logic [7:0] c);
    return (c == 8'h0D) || (c == 8'h0A);
  endfunction

  task automatic modelStep();
    modelLive = 1'b1;
    mErr = 1'b0;
    if (reset) begin
      lineQ.delete();
      lineBad = 1'b0;
      mValid = 1'b0;
      mWord = 32'h0;
      mCnt = 0;
    end else if (mValid) begin
      if (word_ready) mValid = 1'b0;
    end else if (ascii_valid) begin
      if (isTermChar(ascii_in)) begin
        if (lineBad) mErr = 1'b1;
        else if (lineQ.size() > 0) begin
          mValid = 1'b1;
          mCnt = lineQ.size();
          mWord = 32'h0;
          foreach (lineQ[i]) mWord = mWord * 32'd16 + 32'(hexValue(lineQ[i]));
        end
        lineQ.delete();
        lineBad = 1'b0;
      end else if (hexValue(ascii_in) < 0 || lineQ.size() == N) begin
        lineBad = 1'b1;
      end else if (!lineBad) begin
        lineQ.push_back(ascii_in);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Per-cycle comparison plus word/error statistics observed on the DUT outputs.
  int          dutWords = 0;
  int          dutErrs = 0;
  logic [31:0] dutLastWord = 32'h0;
  int          dutLastCnt = 0;
  int          curLen = 0;
  int          lastValidLen = 0;
  bit          prevValid = 1'b0;

  initial forever begin
    @(negedge clk);
    if (modelLive) begin
      checkOutput("ascii_ready", 64'(ascii_ready), 64'(!mValid));
      checkOutput("word_valid", 64'(word_valid), 64'(mValid));
      checkOutput("parse_err", 64'(parse_err), 64'(mErr));
      checkOutput("word_out", 64'(word_out), 64'(mWord));
      checkOutput("digit_count", 64'(digit_count), 64'(mCnt));
      if (word_valid === 1'b1) begin
        if (!prevValid) begin
          dutWords++;
          dutLastWord = word_out;
          dutLastCnt = int'(digit_count);
          curLen = 0;
        end
        curLen++;
      end else if (prevValid) begin
        lastValidLen = curLen;
      end
      prevValid = (word_valid === 1'b1);
      if (parse_err === 1'b1) dutErrs++;
    end
  end

  // 0: word_ready low, 1: high, 2: random each cycle.
  int readyMode = 1;
  initial forever begin
    @(posedge clk);
    #1;
    case (readyMode)
      0:       word_ready = 1'b0;
      1:       word_ready = 1'b1;
      default: word_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic applyStimulus(input logic [7:0] c);
    int guard = 0;
    bit done = 1'b0;
    ascii_in = c;
    ascii_valid = 1'b1;
    while (!done && guard < 100) begin
      @(negedge clk);
      if (ascii_ready === 1'b1) done = 1'b1;
      guard++;
    end
    checkOutput("sendTimeout", 64'(done), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic sendLine(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
  endtask

  task automatic idleCycles(input int n);
    ascii_valid = 1'b0;
    ascii_in = 8'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic resetPulse();
    ascii_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [7:0] randChar();
    string hexChars = "0123456789ABCDEF";
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return hexChars[$urandom_range(0, 15)];
      6:       return 8'(8'h61 + $urandom_range(0, 5));
      7:       return 8'(8'h67 + $urandom_range(0, 19));
      8:       return 8'($urandom_range(0, 255));
      default: return 8'(8'h47 + $urandom_range(0, 10));
    endcase
  endfunction

  typedef struct {
    string       name;
    string       text;
    bit          hasWord;
    logic [31:0] word;
    int          cnt;
    int          errs;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    int e0;

    vecs.push_back('{"deadbeef", "DEADBEEF\015", 1'b1, 32'hDEADBEEF, 8, 0});
    vecs.push_back('{"singleA", "A\015", 1'b1, 32'h0000000A, 1, 0});
    vecs.push_back('{"overflow", "123456789\015", 1'b0, 32'h0, 0, 1});
    vecs.push_back('{"afterOvf", "7\015", 1'b1, 32'h00000007, 1, 0});
    vecs.push_back('{"invalidG", "12G4\015", 1'b0, 32'h0, 0, 1});
    vecs.push_back('{"emptyLines", "\015\012\015", 1'b0, 32'h0, 0, 0});
    vecs.push_back('{"zeros8", "00000000\012", 1'b1, 32'h00000000, 8, 0});
    vecs.push_back('{"crlf", "F\015\012", 1'b1, 32'h0000000F, 1, 0});
    vecs.push_back('{"junkFirst", "x\012", 1'b0, 32'h0, 0, 1});
    vecs.push_back('{"mixed", "9A0C\012", 1'b1, 32'h00009A0C, 4, 0});
`ifdef ASCII_HEX_LOWERCASE_EN
    vecs.push_back('{"lower", "ab\015", 1'b1, 32'h000000AB, 2, 0});
`else
    vecs.push_back('{"lower", "ab\015", 1'b0, 32'h0, 0, 1});
`endif

    reset = 1'b1;
    readyMode = 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst.ascii_ready", 64'(ascii_ready), 64'(1));
    checkOutput("rst.word_valid", 64'(word_valid), 64'(0));
    checkOutput("rst.word_out", 64'(word_out), 64'(0));
    checkOutput("rst.digit_count", 64'(digit_count), 64'(0));
    checkOutput("rst.parse_err", 64'(parse_err), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    idleCycles(2);

    foreach (vecs[i]) begin
      w0 = dutWords;
      e0 = dutErrs;
      sendLine(vecs[i].text);
      idleCycles(4);
      checkOutput({vecs[i].name, ".words"}, 64'(dutWords - w0), 64'(vecs[i].hasWord ? 1 : 0));
      checkOutput({vecs[i].name, ".errs"}, 64'(dutErrs - e0), 64'(vecs[i].errs));
      if (vecs[i].hasWord) begin
        checkOutput({vecs[i].name, ".word"}, 64'(dutLastWord), 64'(vecs[i].word));
        checkOutput({vecs[i].name, ".cnt"}, 64'(dutLastCnt), 64'(vecs[i].cnt));
        checkOutput({vecs[i].name, ".validLen"}, 64'(lastValidLen), 64'(1));
      end
    end

    // Backpressure: word held in DONE while a new character waits unconsumed.
    readyMode = 0;
    idleCycles(2);
    sendLine("1F\012");
    ascii_in = 8'h41;
    ascii_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp.word_valid", 64'(word_valid), 64'(1));
      checkOutput("bp.ascii_ready", 64'(ascii_ready), 64'(0));
      checkOutput("bp.word_out", 64'(word_out), 64'(32'h1F));
      checkOutput("bp.digit_count", 64'(digit_count), 64'(2));
      @(posedge clk);
      #1;
    end
    readyMode = 1;
    applyStimulus(8'h41);
    applyStimulus(8'h0D);
    idleCycles(4);
    checkOutput("bp.nextWord", 64'(dutLastWord), 64'(32'hA));
    checkOutput("bp.nextCnt", 64'(dutLastCnt), 64'(1));

    // Reset in the middle of a line.
    w0 = dutWords;
    e0 = dutErrs;
    sendLine("ABC");
    resetPulse();
    sendLine("5\015");
    idleCycles(4);
    checkOutput("midRst.words", 64'(dutWords - w0), 64'(1));
    checkOutput("midRst.errs", 64'(dutErrs - e0), 64'(0));
    checkOutput("midRst.word", 64'(dutLastWord), 64'(32'h5));
    checkOutput("midRst.cnt", 64'(dutLastCnt), 64'(1));

    // Reset while a word is pending drops it silently.
    readyMode = 0;
    e0 = dutErrs;
    sendLine("3C\015");
    idleCycles(2);
    @(negedge clk);
    checkOutput("doneRst.pending", 64'(word_valid), 64'(1));
    @(posedge clk);
    #1;
    resetPulse();
    @(negedge clk);
    checkOutput("doneRst.dropped", 64'(word_valid), 64'(0));
    checkOutput("doneRst.ready", 64'(ascii_ready), 64'(1));
    @(posedge clk);
    #1;
    readyMode = 1;
    sendLine("9\015");
    idleCycles(4);
    checkOutput("doneRst.errs", 64'(dutErrs - e0), 64'(0));
    checkOutput("doneRst.nextWord", 64'(dutLastWord), 64'(32'h9));

    // Random traffic with random downstream backpressure and occasional resets.
    readyMode = 2;
    for (int l = 0; l < 150; l++) begin
      int len;
      len = $urandom_range(0, 10);
      if ($urandom_range(0, 29) == 0) begin
        applyStimulus(randChar());
        resetPulse();
      end
      for (int k = 0; k < len; k++) begin
        applyStimulus(randChar());
        if ($urandom_range(0, 4) == 0) idleCycles($urandom_range(1, 3));
      end
      applyStimulus(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
    end
    readyMode = 1;
    idleCycles(6);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
